// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode/field constants, FSM states and datapath select encodings
// shared by the multicycle RV64 control unit and its instruction decoder.
package riscv_pkg;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [2:0] F3_DOUBLE = 3'b011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  typedef enum logic [2:0] {
    BUSCA = 3'd0, DECODIFICA = 3'd1, EXECUTA = 3'd2, MEMORIA = 3'd3, ESCRITA = 3'd4, ERRO = 3'd5
  } estado_t;
  typedef enum logic [3:0] {
    C_ILEGAL, C_LD, C_SD, C_ADD, C_SUB, C_ADDI, C_BEQ, C_BNE, C_JAL, C_JALR, C_AUIPC, C_LUI
  } classe_t;
  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_sel_t;
  typedef enum logic [1:0] {PC_MAIS4 = 2'd0, PC_IMM = 2'd1, PC_ULA = 2'd2} pc_sel_t;
  typedef enum logic [1:0] {WSEL_ULA = 2'd0, WSEL_MEM = 2'd1, WSEL_PC4 = 2'd2} wsel_t;
endpackage

// File: rtl/decodificador_instrucao.sv
// decodificador_instrucao: classifies an instruction into one of the supported
// classes (or illegal) and picks the immediate format it uses.
module decodificador_instrucao import riscv_pkg::*; #(
  parameter bit HAB_BNE = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output classe_t    classe,
  output logic       legal,
  output imm_sel_t   imm_sel
);
  always_comb begin
    classe = C_ILEGAL;
    case (opcode)
      OP_LOAD: classe = funct3 == F3_DOUBLE ? C_LD : C_ILEGAL;
      OP_STORE: classe = funct3 == F3_DOUBLE ? C_SD : C_ILEGAL;
      OP_OP: classe = funct3 != F3_ADD ? C_ILEGAL : funct7 == F7_ADD ? C_ADD : funct7 == F7_SUB ? C_SUB : C_ILEGAL;
      OP_IMM: classe = funct3 == F3_ADD ? C_ADDI : C_ILEGAL;
      OP_BRANCH: classe = funct3 == F3_BEQ ? C_BEQ : (HAB_BNE && funct3 == F3_BNE) ? C_BNE : C_ILEGAL;
      OP_JAL: classe = C_JAL;
      OP_JALR: classe = funct3 == 3'b000 ? C_JALR : C_ILEGAL;
      OP_AUIPC: classe = C_AUIPC;
      OP_LUI: classe = C_LUI;
      default: classe = C_ILEGAL;
    endcase
  end
  assign legal = classe != C_ILEGAL;
  always_comb
    imm_sel = classe == C_SD ? IMM_S :
              (classe == C_BEQ || classe == C_BNE) ? IMM_B :
              (classe == C_AUIPC || classe == C_LUI) ? IMM_U :
              classe == C_JAL ? IMM_J : IMM_I;
endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle control FSM for the RV64 datapath with
// memory handshake timeout, sticky illegal flag and retired-instruction counter.
module unidade_controle_multiciclo import riscv_pkg::*; #(
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 15,
  parameter bit HAB_BNE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             eq_zero,
  input  logic             mem_pronto,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic [2:0]       imm_sel,
  output logic             ula_a_sel,
  output logic             ula_b_sel,
  output logic             ula_sub,
  output logic             reg_we,
  output logic [1:0]       reg_wsel,
  output logic             mem_req,
  output logic             mem_we,
  output logic [2:0]       estado,
  output logic             ilegal,
  output logic [CNT_W-1:0] retiradas
);
  estado_t estado_q, prox;
  classe_t classe;
  imm_sel_t imm_dec;
  logic legal, tomado, tempo_esgotado, retira, unused_campos;
  logic ir_we_i, pc_we_i, reg_we_i, mem_req_i, mem_we_i;
  logic [31:0] espera;
  decodificador_instrucao #(.HAB_BNE(HAB_BNE)) u_dec (
    .opcode(instr[6:0]),
    .funct3(instr[14:12]),
    .funct7(instr[31:25]),
    .classe(classe),
    .legal(legal),
    .imm_sel(imm_dec)
  );
  assign unused_campos = ^instr[24:15];
  assign tomado = classe == C_BNE ? !eq_zero : eq_zero;
  assign tempo_esgotado = TIMEOUT != 0 && espera == 32'(TIMEOUT - 1);
  always_comb begin
    prox = estado_q;
    ir_we_i = 1'b0;
    pc_we_i = 1'b0;
    pc_sel = PC_MAIS4;
    reg_we_i = 1'b0;
    mem_req_i = 1'b0;
    mem_we_i = 1'b0;
    retira = 1'b0;
    case (estado_q)
      BUSCA: begin
        ir_we_i = 1'b1;
        prox = DECODIFICA;
      end
      DECODIFICA: prox = legal ? EXECUTA : ERRO;
      EXECUTA: begin
        if (classe inside {C_BEQ, C_BNE, C_JAL, C_JALR}) begin
          pc_we_i = 1'b1;
          retira = 1'b1;
          reg_we_i = classe inside {C_JAL, C_JALR};
          pc_sel = classe == C_JALR ? PC_ULA : (classe == C_JAL || tomado) ? PC_IMM : PC_MAIS4;
          prox = BUSCA;
        end else
          prox = classe inside {C_LD, C_SD} ? MEMORIA : ESCRITA;
      end
      MEMORIA: begin
        mem_req_i = 1'b1;
        mem_we_i = classe == C_SD;
        pc_we_i = mem_pronto && classe == C_SD;
        retira = mem_pronto && classe == C_SD;
        prox = mem_pronto ? (classe == C_SD ? BUSCA : ESCRITA) : tempo_esgotado ? ERRO : MEMORIA;
      end
      ESCRITA: begin
        reg_we_i = 1'b1;
        pc_we_i = 1'b1;
        retira = 1'b1;
        prox = BUSCA;
      end
      default: prox = ERRO;
    endcase
  end
  assign ir_we = ir_we_i && !rst;
  assign pc_we = pc_we_i && !rst;
  assign reg_we = reg_we_i && !rst && instr[11:7] != 5'd0;
  assign mem_req = mem_req_i && !rst;
  assign mem_we = mem_we_i && !rst;
  assign imm_sel = imm_dec;
  assign ula_a_sel = classe == C_AUIPC;
  assign ula_b_sel = classe inside {C_LD, C_SD, C_ADDI, C_JALR, C_AUIPC, C_LUI};
  assign ula_sub = classe inside {C_SUB, C_BEQ, C_BNE};
  assign reg_wsel = classe == C_LD ? WSEL_MEM : (classe == C_JAL || classe == C_JALR) ? WSEL_PC4 : WSEL_ULA;
  assign estado = estado_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q <= BUSCA;
      ilegal <= 1'b0;
      retiradas <= '0;
      espera <= '0;
    end else begin
      estado_q <= prox;
      ilegal <= ilegal || prox == ERRO;
      retiradas <= retiradas + CNT_W'(retira);
      espera <= (estado_q == MEMORIA && prox == MEMORIA) ? espera + 32'd1 : '0;
    end
  end
endmodule
